// File: rtl/axi4_lite_read_arbiter.sv
// Two-master AXI4-Lite read arbiter: IFU and LSU share one memory read port,
// one outstanding transaction, with alternating priority on contention.
module axi4_lite_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  iClock,
    input  logic                  iReset,

    input  logic                  bIFUAXISlaveARIO_arvalid,
    input  logic [ADDR_WIDTH-1:0] bIFUAXISlaveARIO_araddr,
    output logic                  bIFUAXISlaveARIO_arready,
    input  logic                  bIFUAXISlaveRIO_rready,
    output logic                  bIFUAXISlaveRIO_rvalid,
    output logic [DATA_WIDTH-1:0] bIFUAXISlaveRIO_rdata,
    output logic [1:0]            bIFUAXISlaveRIO_rresp,

    input  logic                  bLSUAXISlaveARIO_arvalid,
    input  logic [ADDR_WIDTH-1:0] bLSUAXISlaveARIO_araddr,
    output logic                  bLSUAXISlaveARIO_arready,
    input  logic                  bLSUAXISlaveRIO_rready,
    output logic                  bLSUAXISlaveRIO_rvalid,
    output logic [DATA_WIDTH-1:0] bLSUAXISlaveRIO_rdata,
    output logic [1:0]            bLSUAXISlaveRIO_rresp,

    output logic                  bMemAXIMasterARIO_arvalid,
    output logic [ADDR_WIDTH-1:0] bMemAXIMasterARIO_araddr,
    input  logic                  bMemAXIMasterARIO_arready,
    output logic                  bMemAXIMasterRIO_rready,
    input  logic                  bMemAXIMasterRIO_rvalid,
    input  logic [DATA_WIDTH-1:0] bMemAXIMasterRIO_rdata,
    input  logic [1:0]            bMemAXIMasterRIO_rresp,

    output logic                  oBusy,
    output logic                  oOwner
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and masters hold arvalid until their arready.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } tState;

    tState                 stateReg, stateNext;
    logic                  priorityPtr, priorityNext;
    logic                  ownerReg, ownerNext;
    logic [ADDR_WIDTH-1:0] addrReg, addrNext;
    logic                  ifuGrant, lsuGrant;
    logic                  memArvalid, memRready, deliver;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            stateReg    <= IDLE;
            priorityPtr <= 1'b0;
            ownerReg    <= 1'b0;
            addrReg     <= '0;
        end else begin
            stateReg    <= stateNext;
            priorityPtr <= priorityNext;
            ownerReg    <= ownerNext;
            addrReg     <= addrNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        priorityNext = priorityPtr;
        ownerNext    = ownerReg;
        addrNext     = addrReg;
        ifuGrant     = 1'b0;
        lsuGrant     = 1'b0;
        memArvalid   = 1'b0;
        memRready    = 1'b0;
        deliver      = 1'b0;
        case (stateReg)
            IDLE: begin
                // priorityPtr names the master that wins a tie (0 = IFU, 1 = LSU)
                ifuGrant = bIFUAXISlaveARIO_arvalid && (!bLSUAXISlaveARIO_arvalid || !priorityPtr);
                lsuGrant = bLSUAXISlaveARIO_arvalid && (!bIFUAXISlaveARIO_arvalid || priorityPtr);
                if (ifuGrant) begin
                    ownerNext = 1'b0;
                    addrNext  = bIFUAXISlaveARIO_araddr;
                    stateNext = ADDR;
                end else if (lsuGrant) begin
                    ownerNext = 1'b1;
                    addrNext  = bLSUAXISlaveARIO_araddr;
                    stateNext = ADDR;
                end
            end
            ADDR: begin
                memArvalid = 1'b1;
                if (bMemAXIMasterARIO_arready) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                deliver   = 1'b1;
                memRready = ownerReg ? bLSUAXISlaveRIO_rready : bIFUAXISlaveRIO_rready;
                if (bMemAXIMasterRIO_rvalid && memRready) begin
                    stateNext    = IDLE;
                    priorityNext = ~ownerReg;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Everything handshake-related is forced low while reset is held.
    logic toIfu, toLsu;
    assign toIfu = deliver && !ownerReg && !iReset;
    assign toLsu = deliver &&  ownerReg && !iReset;

    assign bIFUAXISlaveARIO_arready  = ifuGrant && !iReset;
    assign bLSUAXISlaveARIO_arready  = lsuGrant && !iReset;

    assign bIFUAXISlaveRIO_rvalid    = toIfu && bMemAXIMasterRIO_rvalid;
    assign bIFUAXISlaveRIO_rdata     = toIfu ? bMemAXIMasterRIO_rdata : '0;
    assign bIFUAXISlaveRIO_rresp     = toIfu ? bMemAXIMasterRIO_rresp : 2'b00;
    assign bLSUAXISlaveRIO_rvalid    = toLsu && bMemAXIMasterRIO_rvalid;
    assign bLSUAXISlaveRIO_rdata     = toLsu ? bMemAXIMasterRIO_rdata : '0;
    assign bLSUAXISlaveRIO_rresp     = toLsu ? bMemAXIMasterRIO_rresp : 2'b00;

    assign bMemAXIMasterARIO_arvalid = memArvalid && !iReset;
    assign bMemAXIMasterARIO_araddr  = addrReg;
    assign bMemAXIMasterRIO_rready   = memRready && !iReset;

    assign oBusy  = (stateReg != IDLE) && !iReset;
    assign oOwner = ownerReg;

endmodule
